memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline stage directly downstream of the stage-5 microinstruction register. Consumes C5/T5/DATA_ADDR_5/M5, performs the data-memory access selected by M5 through a req/ready handshake, and registers stage-6 results. Freezes upstream stages via `stall` while a memory access is outstanding.

## Interface
- `DATA_W`, 16, data-memory word width
- `MEM_TIMEOUT`, 255, max wait cycles before abort (used only with timeout compiled in)
- `clock` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `C5` in 6 — control field, passed through
- `T5` in 7 — tag field, passed through
- `DATA_ADDR_5` in 11 — data-memory address
- `M5` in 2 — memory op: 00 none, 01 load, 10 store, 11 illegal
- `VALID_5` in 1 — stage-5 contents hold a real instruction
- `WDATA_5` in DATA_W — store data
- `stall` out 1 — freeze stages ≤5
- `mem_req` out 1 — memory request
- `mem_we` out 1 — 1 = write
- `mem_addr` out 11; `mem_wdata` out DATA_W
- `mem_rdata` in DATA_W; `mem_ready` in 1 — access completes on a clock edge where `mem_req && mem_ready`
- `C6` out 6; `T6` out 7; `RDATA_6` out DATA_W; `VALID_6` out 1; `ERR_6` out 1

## Operation
- FSM states: IDLE, WAIT.
- `stall` = (state == WAIT), combinational from state only.
- Accept: edge with state IDLE and `VALID_5`=1.
- Accept with M5 = 00: next edge `C6`/`T6` ← C5/T5, `RDATA_6`←0, `VALID_6`←1, `ERR_6`←0. Stay IDLE.
- Accept with M5 = 11: as 00, with `ERR_6`←1. No memory access.
- Accept with M5 = 01/10: latch C5, T5, address, WDATA_5, op. Go to WAIT. `mem_req`←1, `mem_we`←(M5==10), `mem_addr`, `mem_wdata` are registered and held stable until completion. `VALID_6`←0.
- WAIT, edge with `mem_ready`=1:
  - `VALID_6`←1, `ERR_6`←0.
  - `RDATA_6`←mem_rdata for a load, 0 for a store.
  - `C6`/`T6` ← latched values.
  - `mem_req`←0, go to IDLE.
- `VALID_6` is a one-cycle pulse per instruction. Between pulses it is 0 and C6/T6/RDATA_6 hold their last values. Downstream cannot stall.
- `mem_ready` is ignored while `mem_req`=0.
- IDLE with `VALID_5`=0: `VALID_6`←0, no other change.

## Timing
- Reset: all outputs 0, state IDLE, timeout counter 0. Applies mid-WAIT: request dropped at the reset edge, no `VALID_6` for the aborted instruction.
- Non-memory latency: 1 cycle (accept edge t0 → `VALID_6` high after t0).
- Memory latency: `mem_req` high after t0. Completion edge t0+k, k≥1; result valid after t0+k.
- Zero-wait memory (`mem_ready` constantly 1): result after t0+1, `stall` high for exactly 1 cycle.
- Back-to-back: `stall` is low in the cycle after completion, so the next instruction can be accepted at that edge. Maximum throughput is 1 memory op per 2 cycles, or 1 non-memory op per cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on WAIT entry and increments each WAIT cycle without `mem_ready`.
  - When it reaches MEM_TIMEOUT: `mem_req`←0, `VALID_6`←1, `ERR_6`←1, `RDATA_6`←0, go to IDLE.
  - If `mem_ready` and expiry coincide on the same edge, `mem_ready` wins (normal completion).
- `MEM_TIMEOUT_EN` undefined: no counter, WAIT persists until `mem_ready`, and the MEM_TIMEOUT parameter is unused.

## Structure
- Shared package holds:
  - M-code constants MEM_NONE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10, MEM_ILLEGAL=2'b11
  - field widths C_W=6, T_W=7, ADDR_W=11
  - FSM state typedef
- One sub-module, `mem_timeout_counter` (clear, enable, expired), instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- M5=00, C5=6'h2A, T5=7'h11, VALID_5=1 → next cycle VALID_6=1, C6=6'h2A, T6=7'h11, RDATA_6=0, stall never high.
- Load addr 11'h3F0, mem_ready high after 3 req cycles with mem_rdata=16'hBEEF → mem_addr=11'h3F0, mem_we=0; stall high 3 cycles; VALID_6 pulse with RDATA_6=16'hBEEF.
- Store addr 11'h005, WDATA_5=16'h1234, mem_ready tied 1 → one req cycle with mem_we=1, mem_wdata=16'h1234; VALID_6=1, RDATA_6=0; next instruction accepted the following edge.
- M5=11 → VALID_6=1, ERR_6=1, mem_req stays 0.
- Reset asserted in the 2nd WAIT cycle of a load → mem_req=0 and all outputs 0 after the edge; no VALID_6 for that load.
- `MEM_TIMEOUT_EN`, MEM_TIMEOUT=4, mem_ready held 0 → abort after 4 WAIT cycles with ERR_6=1. Repeat with mem_ready rising on the expiry edge → normal completion, ERR_6=0.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access stage: op codes, field widths and FSM states.
package memory_access_stage_pkg;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_LOAD    = 2'b01;
    localparam logic [1:0] MEM_STORE   = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    localparam int C_W    = 6;
    localparam int T_W    = 7;
    localparam int ADDR_W = 11;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ready bus between the memory access stage (master) and the memory (slave).
interface memory_access_stage_if
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_W = 16
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/memory_access_stage_timeout_counter.sv
// Counts WAIT cycles without mem_ready; expired flags the edge on which the count reaches LIMIT.
module mem_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// Stage-6 memory access: runs the M5-selected load/store over a req/ready bus and stalls upstream meanwhile.
// Define MEM_TIMEOUT_EN to abort accesses that wait MEM_TIMEOUT cycles without mem_ready.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [C_W-1:0]    C5,
    input  logic [T_W-1:0]    T5,
    input  logic [ADDR_W-1:0] DATA_ADDR_5,
    input  logic [1:0]        M5,
    input  logic              VALID_5,
    input  logic [DATA_W-1:0] WDATA_5,
    output logic              stall,
    memory_access_stage_if.master mem,
    output logic [C_W-1:0]    C6,
    output logic [T_W-1:0]    T6,
    output logic [DATA_W-1:0] RDATA_6,
    output logic              VALID_6,
    output logic              ERR_6
);

    state_t state, state_next;

    logic           accept_direct;
    logic           accept_mem;
    logic           mem_done;
    logic           mem_abort;
    logic           timeout_expired;
    logic [C_W-1:0] c_lat;
    logic [T_W-1:0] t_lat;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    mem_timeout_counter #(
        .LIMIT (MEM_TIMEOUT),
        .CNT_W (TO_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept_mem),
        .enable  ((state == WAIT) && !mem.mem_ready),
        .expired (timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (MEM_TIMEOUT != 0);
    assign timeout_expired    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_mem) state_next = WAIT;
            WAIT: if (mem_done || mem_abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode this cycle's events; mem_ready wins over a coinciding timeout expiry.
    always_comb begin
        stall         = (state == WAIT);
        accept_direct = 1'b0;
        accept_mem    = 1'b0;
        mem_done      = 1'b0;
        mem_abort     = 1'b0;
        if (state == IDLE && VALID_5) begin
            case (M5)
                MEM_LOAD, MEM_STORE:  accept_mem    = 1'b1;
                MEM_NONE, MEM_ILLEGAL: accept_direct = 1'b1;
                default:              accept_direct = 1'b1;
            endcase
        end
        if (state == WAIT) begin
            mem_done  = mem.mem_ready;
            mem_abort = !mem.mem_ready && timeout_expired;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_lat         <= '0;
            t_lat         <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            C6            <= '0;
            T6            <= '0;
            RDATA_6       <= '0;
            VALID_6       <= 1'b0;
            ERR_6         <= 1'b0;
        end else begin
            VALID_6 <= 1'b0;
            if (accept_direct) begin
                C6      <= C5;
                T6      <= T5;
                RDATA_6 <= '0;
                VALID_6 <= 1'b1;
                ERR_6   <= (M5 == MEM_ILLEGAL);
            end else if (accept_mem) begin
                c_lat         <= C5;
                t_lat         <= T5;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= (M5 == MEM_STORE);
                mem.mem_addr  <= DATA_ADDR_5;
                mem.mem_wdata <= WDATA_5;
            end else if (mem_done) begin
                C6          <= c_lat;
                T6          <= t_lat;
                RDATA_6     <= mem.mem_we ? '0 : mem.mem_rdata;
                VALID_6     <= 1'b1;
                ERR_6       <= 1'b0;
                mem.mem_req <= 1'b0;
            end else if (mem_abort) begin
                C6          <= c_lat;
                T6          <= t_lat;
                RDATA_6     <= '0;
                VALID_6     <= 1'b1;
                ERR_6       <= 1'b1;
                mem.mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage; timeout steps run only when MEM_TIMEOUT_EN is defined.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    localparam int DATA_W = 16;

    logic              clock;
    logic              reset;
    logic [C_W-1:0]    C5;
    logic [T_W-1:0]    T5;
    logic [ADDR_W-1:0] DATA_ADDR_5;
    logic [1:0]        M5;
    logic              VALID_5;
    logic [DATA_W-1:0] WDATA_5;
    logic              stall;
    logic [C_W-1:0]    C6;
    logic [T_W-1:0]    T6;
    logic [DATA_W-1:0] RDATA_6;
    logic              VALID_6;
    logic              ERR_6;

    int checks;
    int failures;

    memory_access_stage_if #(.DATA_W(DATA_W)) mem_if ();

    memory_access_stage #(
        .DATA_W      (DATA_W),
        .MEM_TIMEOUT (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .C5          (C5),
        .T5          (T5),
        .DATA_ADDR_5 (DATA_ADDR_5),
        .M5          (M5),
        .VALID_5     (VALID_5),
        .WDATA_5     (WDATA_5),
        .stall       (stall),
        .mem         (mem_if.master),
        .C6          (C6),
        .T6          (T6),
        .RDATA_6     (RDATA_6),
        .VALID_6     (VALID_6),
        .ERR_6       (ERR_6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] m, input logic [C_W-1:0] c,
                                 input logic [T_W-1:0] t, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        VALID_5     = valid;
        M5          = m;
        C5          = c;
        T5          = t;
        DATA_ADDR_5 = addr;
        WDATA_5     = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = '0;
        tick();
        tick();
        checkOutput("rst_stall",   32'(stall),          32'd0);
        checkOutput("rst_req",     32'(mem_if.mem_req), 32'd0);
        checkOutput("rst_valid6",  32'(VALID_6),        32'd0);
        checkOutput("rst_c6",      32'(C6),             32'd0);
        checkOutput("rst_t6",      32'(T6),             32'd0);
        checkOutput("rst_rdata6",  32'(RDATA_6),        32'd0);
        checkOutput("rst_err6",    32'(ERR_6),          32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] non-memory op");
        applyStimulus(1'b1, MEM_NONE, 6'h2A, 7'h11, 11'h000, 16'h0000);
        tick();
        checkOutput("nop_valid6", 32'(VALID_6),        32'd1);
        checkOutput("nop_c6",     32'(C6),             32'h2A);
        checkOutput("nop_t6",     32'(T6),             32'h11);
        checkOutput("nop_rdata6", 32'(RDATA_6),        32'd0);
        checkOutput("nop_err6",   32'(ERR_6),          32'd0);
        checkOutput("nop_stall",  32'(stall),          32'd0);
        checkOutput("nop_req",    32'(mem_if.mem_req), 32'd0);
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        tick();
        checkOutput("nop_pulse_end", 32'(VALID_6), 32'd0);
        checkOutput("nop_c6_hold",   32'(C6),      32'h2A);

        $display("[TB] load with three request cycles");
        applyStimulus(1'b1, MEM_LOAD, 6'h15, 7'h22, 11'h3F0, 16'h0000);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        checkOutput("ld_req1",    32'(mem_if.mem_req),  32'd1);
        checkOutput("ld_addr",    32'(mem_if.mem_addr), 32'h3F0);
        checkOutput("ld_we",      32'(mem_if.mem_we),   32'd0);
        checkOutput("ld_stall1",  32'(stall),           32'd1);
        checkOutput("ld_valid6a", 32'(VALID_6),         32'd0);
        tick();
        checkOutput("ld_stall2",  32'(stall),           32'd1);
        checkOutput("ld_addr2",   32'(mem_if.mem_addr), 32'h3F0);
        tick();
        checkOutput("ld_stall3",  32'(stall),           32'd1);
        checkOutput("ld_valid6b", 32'(VALID_6),         32'd0);
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = 16'hBEEF;
        tick();
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        checkOutput("ld_valid6", 32'(VALID_6),        32'd1);
        checkOutput("ld_rdata6", 32'(RDATA_6),        32'hBEEF);
        checkOutput("ld_c6",     32'(C6),             32'h15);
        checkOutput("ld_t6",     32'(T6),             32'h22);
        checkOutput("ld_err6",   32'(ERR_6),          32'd0);
        checkOutput("ld_stall0", 32'(stall),          32'd0);
        checkOutput("ld_req0",   32'(mem_if.mem_req), 32'd0);
        tick();
        checkOutput("ld_pulse_end",  32'(VALID_6), 32'd0);
        checkOutput("ld_rdata_hold", 32'(RDATA_6), 32'hBEEF);

        $display("[TB] zero-wait store then back-to-back op");
        mem_if.mem_ready = 1'b1;
        applyStimulus(1'b1, MEM_STORE, 6'h03, 7'h44, 11'h005, 16'h1234);
        tick();
        checkOutput("st_req",   32'(mem_if.mem_req),   32'd1);
        checkOutput("st_we",    32'(mem_if.mem_we),    32'd1);
        checkOutput("st_wdata", 32'(mem_if.mem_wdata), 32'h1234);
        checkOutput("st_addr",  32'(mem_if.mem_addr),  32'h005);
        checkOutput("st_stall", 32'(stall),            32'd1);
        applyStimulus(1'b1, MEM_NONE, 6'h07, 7'h08, 11'h000, 16'h0000);
        tick();
        checkOutput("st_valid6", 32'(VALID_6),        32'd1);
        checkOutput("st_rdata6", 32'(RDATA_6),        32'd0);
        checkOutput("st_c6",     32'(C6),             32'h03);
        checkOutput("st_t6",     32'(T6),             32'h44);
        checkOutput("st_stall0", 32'(stall),          32'd0);
        checkOutput("st_req0",   32'(mem_if.mem_req), 32'd0);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        checkOutput("b2b_valid6", 32'(VALID_6),        32'd1);
        checkOutput("b2b_c6",     32'(C6),             32'h07);
        checkOutput("b2b_t6",     32'(T6),             32'h08);
        checkOutput("b2b_req",    32'(mem_if.mem_req), 32'd0);
        mem_if.mem_ready = 1'b0;
        tick();

        $display("[TB] illegal op");
        applyStimulus(1'b1, MEM_ILLEGAL, 6'h1F, 7'h7F, 11'h7FF, 16'hFFFF);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        checkOutput("ill_valid6", 32'(VALID_6),        32'd1);
        checkOutput("ill_err6",   32'(ERR_6),          32'd1);
        checkOutput("ill_req",    32'(mem_if.mem_req), 32'd0);
        checkOutput("ill_stall",  32'(stall),          32'd0);
        checkOutput("ill_c6",     32'(C6),             32'h1F);
        checkOutput("ill_rdata6", 32'(RDATA_6),        32'd0);
        tick();
        checkOutput("ill_pulse_end", 32'(VALID_6),        32'd0);
        checkOutput("ill_req_after", 32'(mem_if.mem_req), 32'd0);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, MEM_LOAD, 6'h0A, 7'h0B, 11'h123, 16'h0000);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        checkOutput("rw_req1", 32'(mem_if.mem_req), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rw_req",    32'(mem_if.mem_req),  32'd0);
        checkOutput("rw_addr",   32'(mem_if.mem_addr), 32'd0);
        checkOutput("rw_stall",  32'(stall),           32'd0);
        checkOutput("rw_valid6", 32'(VALID_6),         32'd0);
        checkOutput("rw_c6",     32'(C6),              32'd0);
        checkOutput("rw_t6",     32'(T6),              32'd0);
        checkOutput("rw_rdata6", 32'(RDATA_6),         32'd0);
        checkOutput("rw_err6",   32'(ERR_6),           32'd0);
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = 16'h5555;
        tick();
        checkOutput("rw_no_pulse", 32'(VALID_6),        32'd0);
        checkOutput("rw_ready_ign", 32'(mem_if.mem_req), 32'd0);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'h0000;

`ifdef MEM_TIMEOUT_EN
        $display("[TB] timeout abort");
        applyStimulus(1'b1, MEM_LOAD, 6'h21, 7'h31, 11'h0F0, 16'h0000);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("to_stall", 32'(stall),   32'd1);
            checkOutput("to_valid", 32'(VALID_6), 32'd0);
            tick();
        end
        checkOutput("to_stall_w4", 32'(stall), 32'd1);
        tick();
        checkOutput("to_valid6", 32'(VALID_6),        32'd1);
        checkOutput("to_err6",   32'(ERR_6),          32'd1);
        checkOutput("to_rdata6", 32'(RDATA_6),        32'd0);
        checkOutput("to_req",    32'(mem_if.mem_req), 32'd0);
        checkOutput("to_stall0", 32'(stall),          32'd0);

        $display("[TB] ready on expiry edge");
        applyStimulus(1'b1, MEM_LOAD, 6'h22, 7'h32, 11'h0F1, 16'h0000);
        tick();
        applyStimulus(1'b0, MEM_NONE, '0, '0, '0, '0);
        tick();
        tick();
        tick();
        checkOutput("tr_stall", 32'(stall), 32'd1);
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = 16'hCAFE;
        tick();
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        checkOutput("tr_valid6", 32'(VALID_6),        32'd1);
        checkOutput("tr_err6",   32'(ERR_6),          32'd0);
        checkOutput("tr_rdata6", 32'(RDATA_6),        32'hCAFE);
        checkOutput("tr_req",    32'(mem_if.mem_req), 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
